// File: rtl/key_en_ctl_multi_if.sv
// Trigger/mode/clear inputs and enable outputs of the multi-channel key enable controller.
interface key_en_ctl_multi_if #(
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0] trig;
  logic [1:0]        mode_sel;
  logic              clr;
  logic [CH_NUM-1:0] en;
  logic              any_en;

  modport master (output trig, mode_sel, clr, input en, any_en);
  modport slave  (input trig, mode_sel, clr, output en, any_en);
endinterface

// File: rtl/key_en_ctl_multi.sv
// Per-channel trigger-to-enable controller: timed one-shot, toggle latch or level follow,
// with global clear, mode-change flush and an OR-reduced enable.
module key_en_ch #(
  parameter int CNT_W        = 24,
  parameter int PULSE_CYCLES = 5_000_000,
  parameter int RETRIG       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rise,
  input  logic       trig_d,
  input  logic [1:0] mode,
  input  logic       flush,
  output logic       en,
  output logic       en_nxt
);
  typedef enum logic [1:0] {IDLE, PULSE, LATCH} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      en    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      en    <= en_nxt;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    en_nxt  = en;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
      en_nxt  = 1'b0;
    end else if (mode == 2'd2) begin
      state_n = IDLE;
      cnt_n   = '0;
      en_nxt  = trig_d;
    end else begin
      case (state)
        IDLE: if (rise) begin
          en_nxt = 1'b1;
          if (mode == 2'd1) begin
            state_n = LATCH;
          end else begin
            state_n = PULSE;
            cnt_n   = RELOAD;
          end
        end
        // cnt counts the remaining cycles after this one, so the enable lasts PULSE_CYCLES
        PULSE: begin
          if (rise && RETRIG != 0) begin
            cnt_n = RELOAD;
          end else if (cnt == '0) begin
            state_n = IDLE;
            en_nxt  = 1'b0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        LATCH: if (rise) begin
          state_n = IDLE;
          en_nxt  = 1'b0;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          en_nxt  = 1'b0;
        end
      endcase
    end
  end
endmodule

module key_en_ctl_multi #(
  parameter int CH_NUM       = 4,
  parameter int CNT_W        = 24,
  parameter int PULSE_CYCLES = 5_000_000,
  parameter int RETRIG       = 1
) (
  input logic             clk,
  input logic             rst_n,
  key_en_ctl_multi_if.slave bus
);
  logic [CH_NUM-1:0] trig_d, rise, en, en_nxt;
  logic [1:0]        mode_q;
  logic              flush;

  assign rise   = bus.trig & ~trig_d;
  assign flush  = bus.clr || (bus.mode_sel != mode_q);
  assign bus.en = en;

  // History also tracks the key while in reset, so a key held through reset is not a press.
  always_ff @(posedge clk) trig_d <= bus.trig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= 2'd0;
      bus.any_en <= 1'b0;
    end else begin
      mode_q     <= bus.mode_sel;
      bus.any_en <= |en_nxt;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    key_en_ch #(
      .CNT_W       (CNT_W),
      .PULSE_CYCLES(PULSE_CYCLES),
      .RETRIG      (RETRIG)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .rise  (rise[i]),
      .trig_d(trig_d[i]),
      .mode  (mode_q),
      .flush (flush),
      .en    (en[i]),
      .en_nxt(en_nxt[i])
    );
  end
endmodule

// File: tb/tb_key_en_ctl_multi.sv
// Bench for key_en_ctl_multi: directed scenarios plus random traffic against a behavioural model.
module tb_key_en_ctl_multi;
  localparam int CH = 4;
  localparam int P  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] trig;
  logic [1:0] mode;
  logic       clr;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  key_en_ctl_multi_if #(.CH_NUM(CH)) bus1 ();
  key_en_ctl_multi_if #(.CH_NUM(CH)) bus0 ();

  assign bus1.trig = trig;  assign bus1.mode_sel = mode;  assign bus1.clr = clr;
  assign bus0.trig = trig;  assign bus0.mode_sel = mode;  assign bus0.clr = clr;

  key_en_ctl_multi #(.CH_NUM(CH), .CNT_W(24), .PULSE_CYCLES(P), .RETRIG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  key_en_ctl_multi #(.CH_NUM(CH), .CNT_W(24), .PULSE_CYCLES(P), .RETRIG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  // Model: index 0 is the RETRIG=0 part, index 1 the RETRIG=1 part.
  // rem = enable cycles still owed by a one-shot; on = current enable.
  int         rem [2][CH];
  bit         on  [2][CH];
  bit   [3:0] prev;
  bit   [1:0] mode_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model();
    bit flush, rise;
    if (!rst_n) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < CH; c++) begin rem[r][c] = 0; on[r][c] = 0; end
      mode_r = 2'd0;
    end else begin
      flush = clr || (mode != mode_r);
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < CH; c++) begin
          rise = trig[c] && !prev[c];
          if (flush) begin
            rem[r][c] = 0; on[r][c] = 0;
          end else if (mode_r == 2'd2) begin
            on[r][c] = prev[c];
          end else if (mode_r == 2'd1) begin
            if (rise) on[r][c] = !on[r][c];
          end else begin
            if (rise && (rem[r][c] == 0 || r == 1)) rem[r][c] = P;
            else if (rem[r][c] > 0) rem[r][c]--;
            on[r][c] = rem[r][c] > 0;
          end
        end
      mode_r = mode;
    end
    prev = trig;
  endtask

  function automatic logic [3:0] exp_en(input int r);
    logic [3:0] v;
    for (int c = 0; c < CH; c++) v[c] = on[r][c];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("en_rt1", 32'(bus1.en), 32'(exp_en(1)));
    chk("any_rt1", 32'(bus1.any_en), 32'(|exp_en(1)));
    chk("en_rt0", 32'(bus0.en), 32'(exp_en(0)));
    chk("any_rt0", 32'(bus0.any_en), 32'(|exp_en(0)));
  endtask

  initial begin
    rst_n = 1'b0; trig = 4'hF; mode = 2'd0; clr = 1'b0;
    // Reset with all keys held
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_en", 32'(bus1.en), 0);
      chk("rst_any", 32'(bus1.any_en), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_norise", 32'(bus1.en), 0);
    end
    trig = 4'h0;
    repeat (3) tick();

    // One-shot on channel 0, key held 20 cycles
    trig = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("os_en", 32'(bus1.en), (k < 4) ? 1 : 0);
      chk("os_any", 32'(bus1.any_en), (k < 4) ? 1 : 0);
    end
    trig = 4'h0;
    tick();

    // Retrigger on channel 1: rises at k=0 and k=2
    for (int k = 0; k < 8; k++) begin
      trig = (k == 0 || k == 2) ? 4'b0010 : 4'b0000;
      tick();
      chk("retrig1", 32'(bus1.en[1]), (k <= 5) ? 1 : 0);
      chk("retrig0", 32'(bus0.en[1]), (k <= 3) ? 1 : 0);
    end

    // Toggle mode
    mode = 2'd1;
    repeat (2) tick();
    for (int e = 1; e <= 16; e++) begin
      trig = {e == 9, (e == 5 || e == 9 || e == 15), 2'b00};
      tick();
      chk("tog_ch2", 32'(bus1.en[2]), ((e >= 5 && e < 9) || e >= 15) ? 1 : 0);
      chk("tog_ch3", 32'(bus1.en[3]), (e >= 9) ? 1 : 0);
    end
    trig = 4'b0011;
    tick();
    trig = 4'b0000;
    tick();
    chk("latch_all", 32'(bus1.en), 32'hF);

    // Clear beats a simultaneous rise; a held key gives no re-latch afterwards
    clr = 1'b1; trig = 4'b0001;
    tick();
    chk("clr_en", 32'(bus1.en), 0);
    clr = 1'b0;
    tick();
    chk("clr_nolatch", 32'(bus1.en), 0);
    trig = 4'b0000;
    tick();

    // Mode switch in the middle of a one-shot
    mode = 2'd0;
    repeat (2) tick();
    trig = 4'b0001;
    tick();
    chk("ms_start", 32'(bus1.en), 1);
    trig = 4'b0000; mode = 2'd2;
    tick();
    chk("ms_flush", 32'(bus1.en), 0);
    repeat (8) tick();
    trig = 4'b0001;
    tick();
    chk("fol_lag", 32'(bus1.en[0]), 0);
    tick();
    chk("fol_on", 32'(bus1.en[0]), 1);
    trig = 4'b0000;
    repeat (2) tick();
    chk("fol_off", 32'(bus1.en[0]), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(3) == 0) trig[c] = ~trig[c];
      if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
      clr   = ($urandom_range(49) == 0);
      rst_n = ($urandom_range(199) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
